seg7_frame_capture: RTL and testbench
=====================================

Name: seg7_frame_capture

Overview:
- Inverse of the clock's BCD-to-7-segment path. Samples the multiplexed segment bus (segment lines plus one-hot digit select) and decodes each digit's pattern back to BCD.
- Assembles one full display frame (all digits) and hands it downstream over a valid/ready handshake.
- Used for display loopback self-test and for checking the digital clock's rendered time.

Parameters:
N_DIGITS, 6, number of multiplexed digits (HH:MM:SS); legal range 1..8
STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured; must be >= 2
CNT_W, $clog2(STABLE_CYCLES+1), run-length counter width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
seg_in  input  7  segment lines, active-high; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g
dig_sel  input  N_DIGITS  digit enable, active-high, expected one-hot; bit i selects digit i
frame_bcd  output  4*N_DIGITS  captured frame; nibble i = digit i
frame_err  output  N_DIGITS  bit i set means digit i held an unrecognised pattern
frame_valid  output  1  frame_bcd/frame_err hold a valid frame
frame_ready  input  1  downstream accepts the frame when high together with frame_valid

Behaviour:
- Clock and reset: one clock domain. rst_n is asynchronous and active-low: asserting it clears all state immediately; deassertion is synchronous to clk. This is the already-decided part of the interface: one clock, reset asynchronous and active-low.
- Reset values: frame_bcd=0, frame_err=0, frame_valid=0, input sample register=0, run counter=0, shadow=0, capture mask=0.
- Input stage:
  - seg_in and dig_sel are registered every edge.
  - The run counter resets to 1 when the new sample differs from the held sample. Otherwise it increments, saturating at STABLE_CYCLES.
- Capture condition: the run counter transitions to exactly STABLE_CYCLES, and the held dig_sel is exactly one-hot.
  - There is one capture per stable window; no re-capture while the counter is saturated.
  - Inputs held constant from edge k capture at edge k+STABLE_CYCLES.
  - Zero-hot or multi-hot dig_sel never captures. The counter still runs, and a later change to one-hot starts a fresh window.
- Decode table (seg -> code), exact 7-bit match:
  - 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4
  - 1011011->5, 1011111->6, 1110010->7, 1111111->8, 1111011->9
  - 0000000->4'hE (blank), err=0
  - any other pattern->4'hF, err=1
- On capture of digit i: shadow nibble i and shadow err bit i are overwritten (latest wins), and mask bit i is set.
- Frame transfer: at any edge where mask is all-ones and (frame_valid==0 or frame_ready==1):
  - frame_bcd/frame_err <= shadow, frame_valid <= 1, mask <= 0.
  - If a capture occurs on the same edge, its mask bit is set, and its shadow update applies after the copy, so it belongs to the next frame.
- Handshake:
  - If frame_valid && frame_ready and no transfer occurs, frame_valid <= 0.
  - While frame_valid is high and frame_ready is low, frame outputs are stable.
  - Captures keep updating shadow/mask meanwhile (no loss signalling; latest data wins).
- Latency: final digit captured at edge E with output empty -> frame_valid high after edge E+1.
- Reset mid-frame discards the partial shadow and any pending frame.

Decomposition:
- Package seg7_pkg:
  - segment pattern constants SEG_0..SEG_9 and SEG_BLANK
  - code constants CODE_BLANK=4'hE and CODE_INVALID=4'hF
  - segment bit-index localparams
- Sub-module seg7_decode: purely combinational 7-bit pattern -> {err, code[3:0]}. It is instantiated once on the held sample.
- The top level holds the input register, run counter, shadow, mask and handshake logic.

Test Plan:
- Reset/idle: assert rst_n=0 mid-run with frame_valid=1 -> all outputs 0 immediately; no frame until a complete new scan.
- Full scan: N_DIGITS=6, STABLE_CYCLES=4, frame_ready=1; present digits 1,2,3,4,5,9 each for 6 cycles -> frame_valid asserts for one handshake. frame_bcd=24'h954321, frame_err=0. Valid rises 1 edge after digit 5's capture.
- Glitch rejection: hold digit 0 with pattern 1111110 for only 3 cycles, then 1011011 for 4 cycles -> digit 0 captured as 5, never 0.
- Invalid/blank/select faults:
  - pattern 1000000 -> nibble F, err=1
  - 0000000 -> nibble E, err=0
  - dig_sel=6'b000011 or 6'b000000 held 10 cycles -> mask unchanged, no capture.
- Backpressure: frame_ready=0 after the first frame, then rescan with new values -> frame_bcd unchanged while stalled. On frame_ready=1, the first frame is accepted, and the second frame (latest values) transfers on the same edge with frame_valid staying 1.
- Same-edge capture: the last digit of frame 2 completes on the transfer edge while a new digit 0 capture lands -> frame 2 is correct, and mask bit 0 is set for frame 3.

Source files
------------

// File: rtl/seg7_pkg.sv
// ============================================================================
// seg7_pkg : segment patterns, decode codes and segment bit positions
// Rev 1.0
// ============================================================================
`default_nettype none

package seg7_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110010;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] CODE_BLANK   = 4'hE;
    localparam logic [3:0] CODE_INVALID = 4'hF;

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// ============================================================================
// seg7_decode : exact-match 7-segment pattern to BCD code, flags unknowns
// Rev 1.0
// ============================================================================
`default_nettype none

module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_code,
    output logic       o_err
);

    always_comb begin
        o_code = CODE_INVALID;
        o_err  = 1'b0;
        case (i_seg)
            SEG_0:     o_code = 4'd0;
            SEG_1:     o_code = 4'd1;
            SEG_2:     o_code = 4'd2;
            SEG_3:     o_code = 4'd3;
            SEG_4:     o_code = 4'd4;
            SEG_5:     o_code = 4'd5;
            SEG_6:     o_code = 4'd6;
            SEG_7:     o_code = 4'd7;
            SEG_8:     o_code = 4'd8;
            SEG_9:     o_code = 4'd9;
            SEG_BLANK: o_code = CODE_BLANK;
            default:   o_err  = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seg7_frame_capture.sv
// ============================================================================
// seg7_frame_capture : samples a multiplexed 7-segment bus, debounces each
// digit, decodes to BCD and hands complete frames out over valid/ready.
// Rev 1.0
// ============================================================================
`default_nettype none

module seg7_frame_capture
    import seg7_pkg::*;
#(
    parameter int N_DIGITS      = 6,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [N_DIGITS-1:0]     dig_sel,
    output logic [4*N_DIGITS-1:0]   frame_bcd,
    output logic [N_DIGITS-1:0]     frame_err,
    output logic                    frame_valid,
    input  logic                    frame_ready
);

    localparam int               CNT_W     = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    logic [6:0]            r_seg;
    logic [N_DIGITS-1:0]   r_sel;
    logic                  r_diff;
    logic [CNT_W-1:0]      r_cnt;
    logic [4*N_DIGITS-1:0] r_shadow_bcd;
    logic [N_DIGITS-1:0]   r_shadow_err;
    logic [N_DIGITS-1:0]   r_mask;
    logic [4*N_DIGITS-1:0] r_frame_bcd;
    logic [N_DIGITS-1:0]   r_frame_err;
    logic                  r_frame_valid;

    logic                  w_sample_diff;
    logic [CNT_W-1:0]      w_cnt_next;
    logic                  w_capture;
    logic                  w_xfer;
    logic [N_DIGITS-1:0]   w_mask_next;
    logic                  w_valid_next;
    logic [3:0]            w_code;
    logic                  w_err;

    seg7_decode u_decode (
        .i_seg  (r_seg),
        .o_code (w_code),
        .o_err  (w_err)
    );

    assign w_sample_diff = (seg_in != r_seg) || (dig_sel != r_sel);

    // The change flag is registered so the run counter lags the sample by one
    // edge: inputs first seen at edge k are captured at edge k+STABLE_CYCLES.
    always_comb begin
        w_cnt_next = r_cnt;
        if (r_diff) begin
            w_cnt_next = C_CNT_ONE;
        end else if (r_cnt != C_CNT_MAX) begin
            w_cnt_next = r_cnt + C_CNT_ONE;
        end
    end

    assign w_capture = $onehot(r_sel) && (w_cnt_next == C_CNT_MAX) && (r_cnt != C_CNT_MAX);
    assign w_xfer    = (&r_mask) && (!r_frame_valid || frame_ready);

    always_comb begin
        w_mask_next  = w_xfer ? '0 : r_mask;
        if (w_capture) begin
            w_mask_next = w_mask_next | r_sel;
        end
        w_valid_next = r_frame_valid;
        if (w_xfer) begin
            w_valid_next = 1'b1;
        end else if (r_frame_valid && frame_ready) begin
            w_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg  <= '0;
            r_sel  <= '0;
            r_diff <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_seg  <= seg_in;
            r_sel  <= dig_sel;
            r_diff <= w_sample_diff;
            r_cnt  <= w_cnt_next;
        end
    end

    // Frame copy reads the pre-edge shadow, so a same-edge capture lands in
    // the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_bcd  <= '0;
            r_shadow_err  <= '0;
            r_mask        <= '0;
            r_frame_bcd   <= '0;
            r_frame_err   <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            for (int i = 0; i < N_DIGITS; i++) begin
                if (w_capture && r_sel[i]) begin
                    r_shadow_bcd[4*i +: 4] <= w_code;
                    r_shadow_err[i]        <= w_err;
                end
            end
            if (w_xfer) begin
                r_frame_bcd <= r_shadow_bcd;
                r_frame_err <= r_shadow_err;
            end
            r_mask        <= w_mask_next;
            r_frame_valid <= w_valid_next;
        end
    end

    assign frame_bcd   = r_frame_bcd;
    assign frame_err   = r_frame_err;
    assign frame_valid = r_frame_valid;

endmodule

`default_nettype wire

// File: tb/tb_seg7_frame_capture.sv
// ============================================================================
// tb_seg7_frame_capture : directed table-driven bench for seg7_frame_capture
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_seg7_frame_capture;

    localparam logic [6:0] S0 = 7'b1111110;
    localparam logic [6:0] S1 = 7'b0110000;
    localparam logic [6:0] S2 = 7'b1101101;
    localparam logic [6:0] S3 = 7'b1111001;
    localparam logic [6:0] S4 = 7'b0110011;
    localparam logic [6:0] S5 = 7'b1011011;
    localparam logic [6:0] S6 = 7'b1011111;
    localparam logic [6:0] S7 = 7'b1110010;
    localparam logic [6:0] S8 = 7'b1111111;
    localparam logic [6:0] S9 = 7'b1111011;
    localparam logic [6:0] SB = 7'b0000000;

    typedef struct {
        logic [5:0][6:0] pat;
        logic [23:0]     bcd;
        logic [5:0]      err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [5:0]  dig_sel;
    logic [23:0] frame_bcd;
    logic [5:0]  frame_err;
    logic        frame_valid;
    logic        frame_ready;

    int checks   = 0;
    int failures = 0;

    logic [5:0][6:0] cur_pat;
    vec_t            vecs [4];

    seg7_frame_capture #(
        .N_DIGITS      (6),
        .STABLE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .frame_bcd   (frame_bcd),
        .frame_err   (frame_err),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] sel, input logic [6:0] s, input int n);
        dig_sel = sel;
        seg_in  = s;
        repeat (n) @(negedge clk);
    endtask

    // Presents digits first..last for 6 cycles each; optionally checks that
    // valid rises exactly one edge after digit 5 is captured.
    task automatic scan(input int first, input int last, input bit chk_lat);
        for (int d = first; d <= last; d++) begin
            dig_sel = 6'(1 << d);
            seg_in  = cur_pat[d];
            for (int c = 1; c <= 6; c++) begin
                @(negedge clk);
                if (chk_lat && d == 5 && c == 5) chk("latency_pre", 32'(frame_valid), 32'd0);
                if (chk_lat && d == 5 && c == 6) chk("latency_post", 32'(frame_valid), 32'd1);
            end
        end
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!frame_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(frame_valid), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0].pat = {S9, S5, S4, S3, S2, S1};
        vecs[0].bcd = 24'h954321;  vecs[0].err = 6'b000000;
        vecs[1].pat = {7'b1000000, SB, S8, S7, S6, S0};
        vecs[1].bcd = 24'hFE8760;  vecs[1].err = 6'b100000;
        vecs[2].pat = {S5, S6, S7, S8, S9, 7'b0000001};
        vecs[2].bcd = 24'h56789F;  vecs[2].err = 6'b000001;
        vecs[3].pat = {S1, S3, 7'b1111100, S4, S2, S8};
        vecs[3].bcd = 24'h13F428;  vecs[3].err = 6'b001000;

        seg_in      = '0;
        dig_sel     = '0;
        frame_ready = 1'b1;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_bcd", 32'(frame_bcd), 32'd0);
        chk("reset_err", 32'(frame_err), 32'd0);
        chk("reset_valid", 32'(frame_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            cur_pat = vecs[v].pat;
            scan(0, 5, 1'b1);
            chk("table_bcd", 32'(frame_bcd), 32'(vecs[v].bcd));
            chk("table_err", 32'(frame_err), 32'(vecs[v].err));
            @(negedge clk);
            chk("table_valid_drop", 32'(frame_valid), 32'd0);
        end

        // Short run of "0" must be rejected; "5" held exactly 4 cycles wins.
        drive(6'b000001, S0, 3);
        drive(6'b000001, S5, 4);
        cur_pat = {S5, S4, S3, S2, S1, SB};
        scan(1, 5, 1'b1);
        chk("glitch_bcd", 32'(frame_bcd), 32'h543215);
        chk("glitch_err", 32'(frame_err), 32'd0);
        @(negedge clk);

        // Multi-hot and zero-hot selects must not fill digits 0/1.
        cur_pat = {S9, S8, S7, S6, S4, SB};
        scan(2, 5, 1'b0);
        drive(6'b000011, S1, 10);
        drive(6'b000000, S1, 10);
        chk("fault_no_frame", 32'(frame_valid), 32'd0);
        scan(0, 1, 1'b0);
        wait_valid("fault_frame_valid", 4);
        chk("fault_bcd", 32'(frame_bcd), 32'h98764E);
        chk("fault_err", 32'(frame_err), 32'd0);
        @(negedge clk);

        // Backpressure: frame A held while frame B assembles behind it.
        frame_ready = 1'b0;
        cur_pat = {S7, S5, S3, S1, S0, S2};
        scan(0, 5, 1'b1);
        chk("bp_a_bcd", 32'(frame_bcd), 32'h753102);
        cur_pat = {S4, S5, S6, S7, S8, S9};
        scan(0, 5, 1'b0);
        chk("bp_stall_valid", 32'(frame_valid), 32'd1);
        chk("bp_stall_bcd", 32'(frame_bcd), 32'h753102);

        // Release ready on the very edge that captures a new digit 0.
        dig_sel = 6'b000001;
        seg_in  = S3;
        repeat (4) @(negedge clk);
        frame_ready = 1'b1;
        @(negedge clk);
        chk("same_edge_valid", 32'(frame_valid), 32'd1);
        chk("same_edge_bcd", 32'(frame_bcd), 32'h456789);
        @(negedge clk);
        chk("same_edge_drop", 32'(frame_valid), 32'd0);
        cur_pat = {S8, SB, S6, S4, S4, S3};
        scan(1, 5, 1'b1);
        chk("frame3_bcd", 32'(frame_bcd), 32'h8E6443);
        chk("frame3_err", 32'(frame_err), 32'd0);
        @(negedge clk);

        // Reset with a pending frame and a partial next frame.
        frame_ready = 1'b0;
        cur_pat = vecs[0].pat;
        scan(0, 5, 1'b0);
        wait_valid("pre_reset_valid", 4);
        chk("pre_reset_bcd", 32'(frame_bcd), 32'h954321);
        drive(6'b000001, S8, 6);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_bcd", 32'(frame_bcd), 32'd0);
        chk("async_reset_err", 32'(frame_err), 32'd0);
        chk("async_reset_valid", 32'(frame_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        frame_ready = 1'b1;
        scan(1, 5, 1'b0);
        repeat (2) @(negedge clk);
        chk("post_reset_no_frame", 32'(frame_valid), 32'd0);
        scan(0, 0, 1'b0);
        wait_valid("post_reset_valid", 4);
        chk("post_reset_bcd", 32'(frame_bcd), 32'h954321);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
